// File: rtl/pe_omap_drain.sv
// Sequences a PE-row accumulation pass (clear, feed, flush), snapshots all omaps and drains them as a stream.
// Optional DRAIN_OVERLAP_EN: the next pass's clear/feed/flush may run while the previous snapshot drains.
module pe_omap_drain #(
  parameter int NUM_PE    = 8,
  parameter int WORD_SIZE = 32,
  parameter int ACC_LEN_W = 16,
  parameter int FLUSH_CYC = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ACC_LEN_W-1:0]        acc_len,
  input  logic [NUM_PE*WORD_SIZE-1:0] pe_omap_bus,
  output logic                        pe_clr,
  output logic                        feed_en,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int FL_W  = $clog2(FLUSH_CYC + 1);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(NUM_PE - 1);
  localparam logic [FL_W-1:0]      FLUSH_LOAD = FL_W'(FLUSH_CYC);
  localparam logic [FL_W-1:0]      FL_ONE     = FL_W'(1);
  localparam logic [ACC_LEN_W-1:0] ACC_ONE    = ACC_LEN_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_FLUSH, S_CAPTURE} state_t;
  typedef enum logic {D_IDLE, D_DRAIN} dstate_t;

  state_t                r_state, w_state_next;
  dstate_t               r_dstate, w_dstate_next;
  logic [ACC_LEN_W-1:0]  r_acc_len;
  logic [ACC_LEN_W-1:0]  r_acc_cnt, w_acc_cnt_next;
  logic [FL_W-1:0]       r_flush_cnt, w_flush_cnt_next;
  logic [WORD_SIZE-1:0]  r_shadow [NUM_PE];
  logic [WORD_SIZE-1:0]  w_bus_word [NUM_PE];
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_inc;
  logic                  r_pe_clr;
  logic                  r_feed_en;
  logic [WORD_SIZE-1:0]  r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_start_ok;
  logic                  w_start_acc;
  logic                  w_cap_fire;
  logic                  w_hs;
  logic                  w_hs_last;

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_bus_split
    assign w_bus_word[gi] = pe_omap_bus[gi*WORD_SIZE +: WORD_SIZE];
  end

`ifdef DRAIN_OVERLAP_EN
  assign w_start_ok = (r_state == S_IDLE);
`else
  assign w_start_ok = (r_state == S_IDLE) && (r_dstate == D_IDLE);
`endif
  assign w_start_acc = start && w_start_ok;
  // A finished flush only snapshots once the previous drain and its done pulse are over.
  assign w_cap_fire  = (r_state == S_CAPTURE) && (r_dstate == D_IDLE) && !r_done;
  assign w_hs        = r_out_valid && out_ready;
  assign w_hs_last   = w_hs && (r_idx == LAST_IDX);
  assign w_idx_inc   = r_idx + IDX_W'(1);

  always_comb begin
    w_state_next     = r_state;
    w_acc_cnt_next   = r_acc_cnt;
    w_flush_cnt_next = r_flush_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_acc) w_state_next = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_acc_len != '0) begin
          w_state_next   = S_ACCUM;
          w_acc_cnt_next = r_acc_len;
        end else begin
          w_state_next     = S_FLUSH;
          w_flush_cnt_next = FLUSH_LOAD;
        end
      end
      S_ACCUM: begin
        if (r_acc_cnt == ACC_ONE) begin
          w_state_next     = S_FLUSH;
          w_flush_cnt_next = FLUSH_LOAD;
        end else begin
          w_acc_cnt_next = r_acc_cnt - ACC_ONE;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == FL_ONE) w_state_next = S_CAPTURE;
        else                       w_flush_cnt_next = r_flush_cnt - FL_ONE;
      end
      S_CAPTURE: begin
        if (w_cap_fire) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_dstate_next = r_dstate;
    unique case (r_dstate)
      D_IDLE:  if (w_cap_fire) w_dstate_next = D_DRAIN;
      D_DRAIN: if (w_hs_last)  w_dstate_next = D_IDLE;
      default: w_dstate_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_dstate    <= D_IDLE;
      r_acc_len   <= '0;
      r_acc_cnt   <= '0;
      r_flush_cnt <= '0;
      r_idx       <= '0;
      r_pe_clr    <= 1'b1;
      r_feed_en   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_dstate    <= w_dstate_next;
      r_acc_cnt   <= w_acc_cnt_next;
      r_flush_cnt <= w_flush_cnt_next;
      if (w_start_acc) r_acc_len <= acc_len;
      // Outputs are decoded from next state so they line up with the state they describe.
      r_pe_clr    <= (w_state_next == S_CLEAR);
      r_feed_en   <= (w_state_next == S_ACCUM);
      r_busy      <= (w_state_next != S_IDLE) || (w_dstate_next == D_DRAIN);
      r_out_valid <= (w_dstate_next == D_DRAIN);
      r_done      <= w_hs_last;
      if (w_cap_fire) begin
        r_idx      <= '0;
        r_out_data <= w_bus_word[0];
        r_out_last <= (LAST_IDX == '0);
      end else if (w_hs) begin
        if (r_idx == LAST_IDX) begin
          r_idx      <= '0;
          r_out_last <= 1'b0;
        end else begin
          r_idx      <= w_idx_inc;
          r_out_data <= r_shadow[w_idx_inc];
          r_out_last <= (w_idx_inc == LAST_IDX);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_PE; k++) r_shadow[k] <= '0;
    end else if (w_cap_fire) begin
      for (int k = 0; k < NUM_PE; k++) r_shadow[k] <= w_bus_word[k];
    end
  end

  assign pe_clr    = r_pe_clr;
  assign feed_en   = r_feed_en;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pe_omap_drain.sv
// Bench for pe_omap_drain: table of passes checked against a word scoreboard plus reset/overlap sequences.
module tb_pe_omap_drain;
  localparam int NUM_PE    = 8;
  localparam int WORD_SIZE = 32;
  localparam int ACC_LEN_W = 16;
  localparam int FLUSH_CYC = 9;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic [ACC_LEN_W-1:0]        acc_len = '0;
  logic [NUM_PE*WORD_SIZE-1:0] pe_omap_bus;
  logic                        pe_clr, feed_en, out_valid, out_last, busy, done;
  logic                        out_ready = 1'b1;
  logic [WORD_SIZE-1:0]        out_data;

  pe_omap_drain #(
    .NUM_PE(NUM_PE), .WORD_SIZE(WORD_SIZE), .ACC_LEN_W(ACC_LEN_W), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .acc_len(acc_len), .pe_omap_bus(pe_omap_bus),
    .pe_clr(pe_clr), .feed_en(feed_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic last; } exp_t;
  typedef struct { int acc; int seed; int rmode; int exp_feed; int exp_lat; bit extra; } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        vecs[5];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0;
  int          feed_cnt = 0, clr_cnt = 0, hs_cnt = 0, done_cnt = 0, rises = 0;
  int          done_cyc = 0, last_hs_cyc = 0, rise_cyc = 0;
  bit          prev_valid = 0, stall_pend = 0, scramble = 1;
  logic [31:0] stall_data;
  logic        stall_last;
  int          cur_seed = 0;
  logic [31:0] pe_w [NUM_PE];

  function automatic logic [31:0] pat(input int s, input int k);
    logic [15:0] hi, lo;
    if (s == 0) begin
      hi = 16'(k + 1);
      lo = 16'(k + 2);
    end else begin
      hi = 16'(s * 4369 + k * 3);
      lo = 16'(32'hF00F ^ (s << 4) ^ k);
    end
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // PE row model: clear wins, feeding loads the pass pattern, draining scrambles the live bus.
  always @(posedge clk) begin
    for (int k = 0; k < NUM_PE; k++) begin
      if (pe_clr)                      pe_w[k] <= '0;
      else if (feed_en)                pe_w[k] <= pat(cur_seed, k);
      else if (scramble && out_valid)  pe_w[k] <= $urandom;
    end
  end

  always_comb begin
    pe_omap_bus = '0;
    for (int k = 0; k < NUM_PE; k++) pe_omap_bus[k*WORD_SIZE +: WORD_SIZE] = pe_w[k];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (feed_en) feed_cnt++;
      if (pe_clr)  clr_cnt++;
      if (out_valid && !prev_valid) begin
        rises++;
        rise_cyc = cyc;
      end
      prev_valid = out_valid;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_pend && out_valid) begin
        check("stall_data", out_data, stall_data);
        check("stall_last", out_last, stall_last);
      end
      stall_pend = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        $display("word cyc=%0d data=0x%08h last=%0b", cyc, out_data, out_last);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got 0x%08h, expected no word", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", out_data, mon_e.data);
          check("word_last", out_last, mon_e.last);
        end
      end
    end else begin
      prev_valid = 0;
      stall_pend = 0;
    end
  end

  task automatic push_pass(input int acc, input int seed);
    exp_t e;
    for (int k = 0; k < NUM_PE; k++) begin
      e.data = (acc == 0) ? 32'h0 : pat(seed, k);
      e.last = (k == NUM_PE - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_pass(input vec_t v, input string tag);
    int f0, cl0, h0, d0, r0, c0, phase;
    bit pulsed;
    f0 = feed_cnt; cl0 = clr_cnt; h0 = hs_cnt; d0 = done_cnt; r0 = rises;
    cur_seed = v.seed;
    push_pass(v.acc, v.seed);
    @(posedge clk); #1;
    start = 1'b1;
    acc_len = ACC_LEN_W'(v.acc);
    out_ready = 1'b1;
    c0 = cyc;
    phase = 0;
    pulsed = 0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      phase++;
      out_ready = (v.rmode == 0) ? 1'b1 : ((phase % 3) == 0);
      if (v.extra) begin
        if (t == 2) begin
          start = 1'b1;
          acc_len = 16'd100;
        end
`ifndef DRAIN_OVERLAP_EN
        if (!pulsed && rises > r0) begin
          start = 1'b1;
          acc_len = 16'd200;
          pulsed = 1;
        end
`endif
      end
      if (done_cnt > d0) break;
    end
    if (done_cnt == d0) timeout_fail({tag, "_done"});
    out_ready = 1'b1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_feed_cycles"}, feed_cnt - f0, v.exp_feed);
    check({tag, "_clr_cycles"}, clr_cnt - cl0, 1);
    check({tag, "_valid_rises"}, rises - r0, 1);
    check({tag, "_latency"}, rise_cyc - c0, v.exp_lat);
    check({tag, "_handshakes"}, hs_cnt - h0, NUM_PE);
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_done_delay"}, done_cyc - last_hs_cyc, 1);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy_after"}, busy, 1'b0);
    $display("pass %s acc_len=%0d seed=%0d ready_mode=%0d latency=%0d", tag, v.acc, v.seed, v.rmode, rise_cyc - c0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1, h0, r0, d0, d1, w;
    vecs[0] = '{acc: 4,  seed: 0, rmode: 0, exp_feed: 4,  exp_lat: 16, extra: 0};
    vecs[1] = '{acc: 4,  seed: 0, rmode: 1, exp_feed: 4,  exp_lat: 16, extra: 0};
    vecs[2] = '{acc: 0,  seed: 1, rmode: 0, exp_feed: 0,  exp_lat: 12, extra: 0};
    vecs[3] = '{acc: 37, seed: 3, rmode: 1, exp_feed: 37, exp_lat: 49, extra: 0};
    vecs[4] = '{acc: 6,  seed: 6, rmode: 1, exp_feed: 6,  exp_lat: 18, extra: 1};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pe_clr", pe_clr, 1'b1);
    check("rst_feed_en", feed_en, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);

    // Reset dropped in the middle of ACCUM.
    h0 = hs_cnt; r0 = rises;
    cur_seed = 7;
    @(posedge clk); #1;
    start = 1'b1;
    acc_len = 16'd20;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_feed_before", feed_en, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_feed_en", feed_en, 1'b0);
    check("mid_out_valid", out_valid, 1'b0);
    check("mid_pe_clr", pe_clr, 1'b1);
    check("mid_busy", busy, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    f1 = feed_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("mid_no_feed", feed_cnt - f1, 0);
    check("mid_no_words", hs_cnt - h0, 0);
    check("mid_no_valid", rises - r0, 0);
    check("mid_idle_busy", busy, 1'b0);
    check("mid_idle_pe_clr", pe_clr, 1'b0);
    $display("pass reset_mid_accum words=%0d", hs_cnt - h0);

    for (int i = 0; i < 5; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

`ifdef DRAIN_OVERLAP_EN
    // Second pass started while the first drain is stalled.
    scramble = 0;
    f1 = feed_cnt; h0 = hs_cnt; r0 = rises; d0 = done_cnt;
    cur_seed = 4;
    push_pass(3, 4);
    @(posedge clk); #1;
    start = 1'b1;
    acc_len = 16'd3;
    out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    w = 0;
    while (rises == r0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (rises == r0) timeout_fail("ovl_first_valid");
    start = 1'b1;
    acc_len = 16'd2;
    cur_seed = 5;
    push_pass(2, 5);
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("ovl_feed_during_drain", feed_cnt - f1, 5);
    check("ovl_valid_held", out_valid, 1'b1);
    check("ovl_no_hs_stalled", hs_cnt - h0, 0);
    out_ready = 1'b1;
    w = 0;
    while (done_cnt == d0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (done_cnt == d0) timeout_fail("ovl_done1");
    d1 = done_cyc;
    check("ovl_busy_between", busy, 1'b1);
    w = 0;
    while (done_cnt < d0 + 2 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (done_cnt < d0 + 2) timeout_fail("ovl_done2");
    repeat (5) @(posedge clk);
    #1;
    check("ovl_pass2_start", rise_cyc - d1, 2);
    check("ovl_handshakes", hs_cnt - h0, 2 * NUM_PE);
    check("ovl_valid_rises", rises - r0, 2);
    check("ovl_queue_left", exp_q.size(), 0);
    check("ovl_busy_after", busy, 1'b0);
    $display("pass overlap words=%0d", hs_cnt - h0);
    scramble = 1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
